hamming_serial_encoder_p: RTL

- Parametrised single-clock successor to the fixed (15,11) serial Hamming encoder datapath.
- Removes the two divided clocks. Bit-level valid/ready handshakes on both sides do the rate matching.
- Supports any M-parity Hamming code, with an optional extended (SEC-DED) overall parity bit.
- Sits between the serial data source and the serial line driver. Double-buffered, so word n+1 is collected while word n shifts out.

---
 rtl/hamming_serial_encoder_p_if.sv | 22 ++
 rtl/hamming_serial_encoder_p.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/hamming_serial_encoder_p_if.sv
// Bit-serial handshake bundle for hamming_serial_encoder_p.
// The master side is the data source and line driver; the slave side is the encoder.
interface hamming_serial_encoder_p_if;
  logic SERIAL_IN;
  logic IN_VALID;
  logic IN_READY;
  logic SERIAL_OUT;
  logic OUT_VALID;
  logic OUT_READY;
  logic CW_DONE;
  logic BUSY;

  modport master (
    output SERIAL_IN, IN_VALID, OUT_READY,
    input  IN_READY, SERIAL_OUT, OUT_VALID, CW_DONE, BUSY
  );

  modport slave (
    input  SERIAL_IN, IN_VALID, OUT_READY,
    output IN_READY, SERIAL_OUT, OUT_VALID, CW_DONE, BUSY
  );
endinterface

// File: rtl/hamming_serial_encoder_p.sv
// Single-clock serial Hamming encoder. A collect register gathers K data bits while the
// shifter streams out the previous codeword, position 1 first, then the optional P0.
module hamming_serial_encoder_p #(
  parameter int unsigned M        = 4,
  parameter bit          EXTENDED = 1'b1
) (
  input logic                       CLK,
  input logic                       REST,
  input logic                       DEVICE_EN,
  hamming_serial_encoder_p_if.slave bus
);

  localparam int unsigned N   = (1 << M) - 1;
  localparam int unsigned K   = N - M;
  localparam int unsigned L   = N + (EXTENDED ? 1 : 0);
  localparam int unsigned ICW = $clog2(K + 1);
  localparam int unsigned OCW = $clog2(N + 2);

  // Codeword position (1-based) that holds data bit idx.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned res;
    cnt = 0;
    res = 0;
    for (int unsigned pos = 1; pos < 64; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (cnt == idx && res == 0) res = pos;
        cnt++;
      end
    end
    return res;
  endfunction

  // Data bits covered by the parity bit at position 2^j.
  function automatic logic [K-1:0] par_mask(input int unsigned j);
    logic [K-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (((data_pos(i) >> j) & 1) != 0) m = m | (K'(1) << i);
    end
    return m;
  endfunction

  logic [K-1:0]   col_q, col_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic           full_q, full_d;
  logic [L-1:0]   sh_q, sh_d;
  logic           loaded_q, loaded_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;

  logic [N-1:0]   ham_vec;
  logic [L-1:0]   code_vec;
  logic           in_ready;
  logic           in_fire;
  logic           out_fire;
  logic           last_out;
  logic           xfer;

  for (genvar gi = 0; gi < K; gi++) begin : g_data
    assign ham_vec[data_pos(gi) - 1] = col_q[gi];
  end

  for (genvar gj = 0; gj < M; gj++) begin : g_par
    localparam logic [K-1:0] Mask = par_mask(gj);
    assign ham_vec[(1 << gj) - 1] = ^(col_q & Mask);
  end

  if (EXTENDED) begin : g_ext
    assign code_vec = {^ham_vec, ham_vec};
  end else begin : g_plain
    assign code_vec = ham_vec;
  end

  assign in_ready = DEVICE_EN & ~full_q & ~REST;
  assign in_fire  = in_ready & bus.IN_VALID;
  assign out_fire = DEVICE_EN & loaded_q & bus.OUT_READY;
  assign last_out = (out_cnt_q == OCW'(L - 1));
  // Reload on the same edge the final bit leaves, so back-to-back words stay gapless.
  assign xfer     = DEVICE_EN & full_q & (~loaded_q | (out_fire & last_out));

  always_comb begin
    col_d     = col_q;
    in_cnt_d  = in_cnt_q;
    full_d    = full_q;
    sh_d      = sh_q;
    loaded_d  = loaded_q;
    out_cnt_d = out_cnt_q;

    if (in_fire) begin
      col_d = {bus.SERIAL_IN, col_q[K-1:1]};
      if (in_cnt_q == ICW'(K - 1)) begin
        in_cnt_d = '0;
        full_d   = 1'b1;
      end else begin
        in_cnt_d = in_cnt_q + 1'b1;
      end
    end

    if (xfer) begin
      full_d    = 1'b0;
      sh_d      = code_vec;
      loaded_d  = 1'b1;
      out_cnt_d = '0;
    end else if (out_fire) begin
      if (last_out) begin
        sh_d      = '0;
        loaded_d  = 1'b0;
        out_cnt_d = '0;
      end else begin
        sh_d      = sh_q >> 1;
        out_cnt_d = out_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge REST) begin
    if (REST) begin
      col_q     <= '0;
      in_cnt_q  <= '0;
      full_q    <= 1'b0;
      sh_q      <= '0;
      loaded_q  <= 1'b0;
      out_cnt_q <= '0;
    end else begin
      col_q     <= col_d;
      in_cnt_q  <= in_cnt_d;
      full_q    <= full_d;
      sh_q      <= sh_d;
      loaded_q  <= loaded_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.IN_READY   = in_ready;
  assign bus.SERIAL_OUT = loaded_q & sh_q[0];
  assign bus.OUT_VALID  = loaded_q;
  assign bus.CW_DONE    = out_fire & last_out;
  assign bus.BUSY       = (in_cnt_q != '0) | full_q | loaded_q;

endmodule
